useq_next: RTL and testbench

//   Micro-sequencer next-address unit: sits directly upstream of the micro-program counter (upcreg)
//   and drives its load_incr / upc_next inputs. Decodes the sequencing field of the current

---
 rtl/useq_next.sv | 175 +++++++++++++++++
 tb/tb_useq_next.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_next.sv
// Micro-sequencer next-address unit.
// Decodes the sequencing field of the current microword and tells the
// micro-PC register (upcreg) either to increment or to load an address.
// The load decision is combinational so upcreg acts on it at the same clock
// edge. The return stack, its occupancy and the sticky status flags are
// registered.
//
// Dispatch interface: disp_addr is sampled only when disp_valid is high
// during a DISP microword. There is no ready back to the opcode map. While
// disp_valid is low, DISP reloads the current upc, so the microword
// re-executes every cycle until a valid dispatch address arrives.
module useq_next #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int NF    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              upc,
  input  logic [2:0]                 uop,
  input  logic [AW-1:0]              target,
  input  logic [$clog2(NF)-1:0]      cond_sel,
  input  logic [NF-1:0]              flags,
  input  logic [AW-1:0]              disp_addr,
  input  logic                       disp_valid,
  output logic                       load_incr,
  output logic [AW-1:0]              upc_next,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       stk_ovf,
  output logic                       stk_unf,
  output logic                       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  // Sequencing op encodings.
  localparam logic [2:0] UOP_NEXT = 3'd0;
  localparam logic [2:0] UOP_JUMP = 3'd1;
  localparam logic [2:0] UOP_BRT  = 3'd2;
  localparam logic [2:0] UOP_BRF  = 3'd3;
  localparam logic [2:0] UOP_CALL = 3'd4;
  localparam logic [2:0] UOP_RET  = 3'd5;
  localparam logic [2:0] UOP_DISP = 3'd6;
  localparam logic [2:0] UOP_HALT = 3'd7;

  logic [AW-1:0] stk [DEPTH];
  logic          full;
  logic          empty;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [AW-1:0] ret_addr;
  logic          push;
  logic          pop;
  logic          set_ovf;
  logic          set_unf;
  logic          set_halt;

  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  // The next free slot is depth itself. This stays in range because a push
  // is only issued while the stack is not full.
  assign wr_ptr   = depth[PW-1:0];
  assign top_ptr  = depth[PW-1:0] - PW'(1);
  // Return address wraps modulo 2^AW, so a CALL at the last address returns to 0.
  assign ret_addr = upc + AW'(1);

  // Combinational next-address decode and stack/flag update requests.
  // Each op reads only the inputs it needs, so unused fields cannot reach the outputs.
  always_comb begin
    load_incr = 1'b0;
    upc_next  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    set_halt  = 1'b0;
    if (reset) begin
      load_incr = 1'b1;
      upc_next  = '0;
    end else if (halted) begin
      // Park on the halting microword; uop is ignored until reset.
      load_incr = 1'b1;
      upc_next  = upc;
    end else begin
      case (uop)
        UOP_NEXT: begin
          load_incr = 1'b0;
        end
        UOP_JUMP: begin
          load_incr = 1'b1;
          upc_next  = target;
        end
        UOP_BRT: begin
          if (flags[cond_sel] == 1'b1) begin
            load_incr = 1'b1;
            upc_next  = target;
          end
        end
        UOP_BRF: begin
          if (flags[cond_sel] == 1'b0) begin
            load_incr = 1'b1;
            upc_next  = target;
          end
        end
        UOP_CALL: begin
          // The jump is taken even when the stack is full; only the push is dropped.
          load_incr = 1'b1;
          upc_next  = target;
          if (full) begin
            set_ovf = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        UOP_RET: begin
          load_incr = 1'b1;
          if (empty) begin
            upc_next = '0;
            set_unf  = 1'b1;
          end else begin
            upc_next = stk[top_ptr];
            pop      = 1'b1;
          end
        end
        UOP_DISP: begin
          load_incr = 1'b1;
          upc_next  = disp_valid ? disp_addr : upc;
        end
        UOP_HALT: begin
          load_incr = 1'b1;
          upc_next  = upc;
          set_halt  = 1'b1;
        end
        default: begin
          load_incr = 1'b0;
          upc_next  = '0;
        end
      endcase
    end
  end

  // Stack occupancy and sticky status flags; reset abandons the stack contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      halted  <= 1'b0;
    end else begin
      if (push) begin
        depth <= depth + DW'(1);
      end else if (pop) begin
        depth <= depth - DW'(1);
      end
      if (set_ovf) begin
        stk_ovf <= 1'b1;
      end
      if (set_unf) begin
        stk_unf <= 1'b1;
      end
      if (set_halt) begin
        halted <= 1'b1;
      end
    end
  end

  // Return-stack storage. Entries above depth are meaningless, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      stk[wr_ptr] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_useq_next.sv
// Directed testbench for useq_next. Inputs change on the falling edge; the
// combinational outputs are sampled 1 ns later, and the registered state is
// sampled on the following falling edge. A small upcreg model closes the loop
// for the free-running NEXT sequence. Expected return addresses live in exp_q.
module tb_useq_next;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int NF    = 4;

  localparam logic [2:0] NEXT = 3'd0;
  localparam logic [2:0] JUMP = 3'd1;
  localparam logic [2:0] BRT  = 3'd2;
  localparam logic [2:0] BRF  = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;
  localparam logic [2:0] DISP = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  logic                      clk;
  logic                      reset;
  logic [AW-1:0]             upc;
  logic [2:0]                uop;
  logic [AW-1:0]             target;
  logic [$clog2(NF)-1:0]     cond_sel;
  logic [NF-1:0]             flags;
  logic [AW-1:0]             disp_addr;
  logic                      disp_valid;
  logic                      load_incr;
  logic [AW-1:0]             upc_next;
  logic [$clog2(DEPTH):0]    depth;
  logic                      stk_ovf;
  logic                      stk_unf;
  logic                      halted;

  logic                      use_model;
  logic [AW-1:0]             upc_m;
  logic [AW-1:0]             upc_drv;
  logic [AW-1:0]             exp_q[$];
  logic [AW-1:0]             exp_ret;

  int n_checks;
  int n_errors;

  useq_next #(.AW(AW), .DEPTH(DEPTH), .NF(NF)) dut (
    .clk        (clk),
    .reset      (reset),
    .upc        (upc),
    .uop        (uop),
    .target     (target),
    .cond_sel   (cond_sel),
    .flags      (flags),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .load_incr  (load_incr),
    .upc_next   (upc_next),
    .depth      (depth),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf),
    .halted     (halted)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference upcreg: load or increment, used only when use_model is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_m <= '0;
    end else begin
      upc_m <= load_incr ? upc_next : upc_m + AW'(1);
    end
  end

  assign upc = use_model ? upc_m : upc_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one microword and let the combinational outputs settle.
  task automatic apply(input logic [2:0] op, input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
    uop     = op;
    target  = tgt;
    upc_drv = pc;
    #1;
  endtask

  // Let the rising edge commit, then return at the falling edge.
  task automatic next_cycle;
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    use_model  = 1'b0;
    reset      = 1'b1;
    uop        = NEXT;
    target     = '0;
    upc_drv    = '0;
    cond_sel   = '0;
    flags      = '0;
    disp_addr  = '0;
    disp_valid = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_load_incr", load_incr, 1);
    check("rst_upc_next", upc_next, 0);
    check("rst_depth", depth, 0);
    check("rst_ovf", stk_ovf, 0);
    check("rst_unf", stk_unf, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: NEXT x3 with the upcreg model; unused target/flags are X.
    use_model = 1'b1;
    flags     = 'x;
    for (int i = 0; i < 3; i++) begin
      apply(NEXT, 'x, '0);
      check("next_load_incr", load_incr, 0);
      check("next_upc_next", upc_next, 0);
      check("next_upc", upc_m, i);
      next_cycle();
    end
    check("next_upc_end", upc_m, 3);
    use_model = 1'b0;

    // JUMP with X flags must be unaffected.
    apply(JUMP, 5'd17, 5'd3);
    check("jump_load_incr", load_incr, 1);
    check("jump_upc_next", upc_next, 17);
    next_cycle();

    // 2: conditional branches.
    cond_sel = 2'd2;
    flags    = 4'b0100;
    apply(BRT, 5'd12, 5'd5);
    check("brt_taken_li", load_incr, 1);
    check("brt_taken_next", upc_next, 12);
    apply(BRF, 5'd12, 5'd5);
    check("brf_not_li", load_incr, 0);
    check("brf_not_next", upc_next, 0);
    flags = 4'b0000;
    #1;
    check("brf_taken_li", load_incr, 1);
    check("brf_taken_next", upc_next, 12);
    apply(BRT, 5'd12, 5'd5);
    check("brt_not_li", load_incr, 0);
    check("brt_not_next", upc_next, 0);
    flags = 4'b1011;
    #1;
    check("brt_othflags_li", load_incr, 0);
    next_cycle();
    check("branch_depth", depth, 0);

    // 3: CALL at upc=3, RET at upc=22.
    apply(CALL, 5'd20, 5'd3);
    check("call_li", load_incr, 1);
    check("call_next", upc_next, 20);
    next_cycle();
    check("call_depth", depth, 1);
    apply(RET, 'x, 5'd22);
    check("ret_li", load_incr, 1);
    check("ret_next", upc_next, 4);
    next_cycle();
    check("ret_depth", depth, 0);

    // Return address wraps when CALL sits at the last address.
    apply(CALL, 5'd2, 5'd31);
    next_cycle();
    check("wrap_depth", depth, 1);
    apply(RET, 'x, 5'd2);
    check("wrap_li", load_incr, 1);
    check("wrap_next", upc_next, 0);
    next_cycle();
    check("wrap_depth_after", depth, 0);
    check("wrap_no_unf", stk_unf, 0);

    // 4: five nested CALLs, then five RETs.
    for (int i = 0; i < 5; i++) begin
      apply(CALL, 5'(i + 24), 5'(i + 10));
      check("ncall_next", upc_next, i + 24);
      if (exp_q.size() < DEPTH) exp_q.push_back(5'(i + 11));
      next_cycle();
      check("ncall_depth", depth, exp_q.size());
      check("ncall_ovf", stk_ovf, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_ret = (exp_q.size() > 0) ? exp_q.pop_back() : '0;
      apply(RET, 'x, 5'(i));
      check("nret_li", load_incr, 1);
      check("nret_next", upc_next, exp_ret);
      next_cycle();
      check("nret_depth", depth, exp_q.size());
      check("nret_unf", stk_unf, (i == 4) ? 1 : 0);
    end
    check("ovf_sticky", stk_ovf, 1);

    // 5: DISP stalls until disp_valid.
    disp_valid = 1'b0;
    disp_addr  = 'x;
    for (int i = 0; i < 3; i++) begin
      apply(DISP, 'x, 5'd8);
      check("disp_stall_li", load_incr, 1);
      check("disp_stall_next", upc_next, 8);
      next_cycle();
    end
    disp_valid = 1'b1;
    disp_addr  = 5'd9;
    apply(DISP, 'x, 5'd8);
    check("disp_go_next", upc_next, 9);
    next_cycle();
    disp_valid = 1'b0;

    // 6: HALT freezes sequencing and the stack.
    apply(CALL, 5'd7, 5'd6);
    exp_q.push_back(5'd7);
    next_cycle();
    check("pre_halt_depth", depth, exp_q.size());
    apply(HALT, 'x, 5'd7);
    check("halt_li", load_incr, 1);
    check("halt_next", upc_next, 7);
    next_cycle();
    check("halted_set", halted, 1);
    apply(JUMP, 5'd1, 5'd7);
    check("halt_jump_li", load_incr, 1);
    check("halt_jump_next", upc_next, 7);
    next_cycle();
    apply(RET, 'x, 5'd7);
    check("halt_ret_next", upc_next, 7);
    next_cycle();
    check("halt_depth", depth, exp_q.size());
    check("halt_sticky", halted, 1);

    // Asynchronous reset mid-cycle clears everything.
    reset = 1'b1;
    #1;
    check("arst_halted", halted, 0);
    check("arst_depth", depth, 0);
    check("arst_ovf", stk_ovf, 0);
    check("arst_unf", stk_unf, 0);
    check("arst_li", load_incr, 1);
    check("arst_next", upc_next, 0);
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    apply(NEXT, 'x, 5'd0);
    check("post_rst_li", load_incr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
